// File: rtl/sudoku_pkg.sv
// Shared types and width helpers for the constraint-propagation controller.
package sudoku_pkg;

    typedef enum logic [2:0] {
        LOAD,
        PROPAGATE,
        EVAL,
        APPLY,
        OUTPUT
    } state_t;

    typedef enum logic [2:0] {
        ST_NONE,
        ST_SOLVED,
        ST_STALLED,
        ST_CONTRA,
        ST_TIMEOUT
    } status_t;

    // Bits needed for a cell value 0..width (0 means unresolved/empty).
    function automatic int val_w(input int width);
        return $clog2(width + 1);
    endfunction

    // Bits needed for a row-major cell index 0..width*width-1.
    function automatic int cnt_w(input int width);
        return (width * width > 1) ? $clog2(width * width) : 1;
    endfunction

    // Bits needed for an iteration count that saturates at max_iter.
    function automatic int iter_w(input int max_iter);
        return $clog2(max_iter + 1);
    endfunction

endpackage

// File: rtl/propagation_ctrl_cell_decode.sv
// Cell decoder: turns a WIDTH-bit exclusion vector into a resolved value.
// A cell is resolved when exactly one option remains (one 0 bit); the value
// is that bit position + 1, otherwise 0.

// Flags a vector with exactly one bit set.
module one_hot_detector #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic             one_hot_o
);
    // Non-zero and clearing the lowest set bit leaves nothing.
    assign one_hot_o = (vec_i != '0) && ((vec_i & (vec_i - WIDTH'(1))) == '0);
endmodule

module cell_decode
    import sudoku_pkg::*;
#(
    parameter  int WIDTH = 9,
    localparam int VAL_W = val_w(WIDTH)
) (
    input  logic [WIDTH-1:0] cell_i,
    output logic [VAL_W-1:0] value_o,
    output logic             solved_o
);
    logic [WIDTH-1:0] open_bits;

    // Remaining options are the bits not yet excluded.
    assign open_bits = ~cell_i;

    one_hot_detector #(.WIDTH(WIDTH)) u_one_hot (
        .vec_i     (open_bits),
        .one_hot_o (solved_o)
    );

    // Encode the surviving option as a 1-based value; 0 when not unique.
    always_comb begin
        value_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (open_bits[i]) begin
                value_o = VAL_W'(i + 1);
            end
        end
        if (!solved_o) begin
            value_o = '0;
        end
    end
endmodule

// File: rtl/propagation_ctrl.sv
// Sequential wrapper around the combinational elimination solver: loads a
// puzzle cell by cell, iterates the solver's masks into the candidate grid
// until solved/stalled/contradiction/timeout, then streams the values out.
// Optional build macro PROP_PIPE_EN: registers the elimination masks and
// splits each iteration into an EVAL (capture) and APPLY (merge) cycle.
module propagation_ctrl
    import sudoku_pkg::*;
#(
    parameter  int WIDTH    = 9,
    parameter  int N        = 3,
    parameter  int MAX_ITER = 64,
    localparam int VAL_W    = val_w(WIDTH),
    localparam int ITER_W   = iter_w(MAX_ITER)
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [VAL_W-1:0]                      in_value,
    output logic [WIDTH-1:0][WIDTH-1:0][WIDTH-1:0] options,
    input  logic [WIDTH-1:0][WIDTH-1:0][WIDTH-1:0] elim_row,
    input  logic [WIDTH-1:0][WIDTH-1:0][WIDTH-1:0] elim_col,
    input  logic [WIDTH-1:0][WIDTH-1:0][WIDTH-1:0] elim_sector,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [VAL_W-1:0]                      out_value,
    output status_t                               status,
    output logic [ITER_W-1:0]                     iter_count
);
    localparam int CELLS = WIDTH * WIDTH;
    localparam int CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_CELL = CNT_W'(CELLS - 1);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MAX_ITER - 1);
    localparam logic [ITER_W-1:0] ITER_SAT  = ITER_W'(MAX_ITER);

    // Flat row-major view of the grid: index = row*WIDTH + col.
    typedef logic [CELLS-1:0][WIDTH-1:0] grid_t;

    // Sector geometry must be square.
    if (N * N != WIDTH) begin : g_geometry_check
        $error("propagation_ctrl: WIDTH must equal N*N");
    end

    state_t              state_q;
    status_t             status_q;
    grid_t               grid_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ITER_W-1:0]   iter_q;

    grid_t               elim_d;
    grid_t               merged_d;
    logic [WIDTH-1:0]    load_cell_d;
    logic [CELLS-1:0]    cell_full_d;
    logic [CELLS-1:0]    cell_solved_d;
    logic [CELLS-1:0][VAL_W-1:0] cell_val_unused;
    status_t             result_d;
    logic [VAL_W-1:0]    out_dec_value;
    logic                out_solved_unused;

    assign elim_d = elim_row | elim_col | elim_sector;

`ifdef PROP_PIPE_EN
    grid_t elim_q;
    assign merged_d = grid_q | elim_q;
`else
    assign merged_d = grid_q | elim_d;
`endif

    // Per-cell contradiction and resolution flags on the merged grid.
    for (genvar gi = 0; gi < CELLS; gi++) begin : g_cell
        assign cell_full_d[gi] = &merged_d[gi];

        cell_decode #(.WIDTH(WIDTH)) u_cell_dec (
            .cell_i   (merged_d[gi]),
            .value_o  (cell_val_unused[gi]),
            .solved_o (cell_solved_d[gi])
        );
    end

    // End-of-run classification; earlier checks take priority.
    always_comb begin
        result_d = ST_NONE;
        if (|cell_full_d) begin
            result_d = ST_CONTRA;
        end else if (&cell_solved_d) begin
            result_d = ST_SOLVED;
        end else if (merged_d == grid_q) begin
            result_d = ST_STALLED;
        end else if (iter_q == ITER_LAST) begin
            result_d = ST_TIMEOUT;
        end
    end

    // Given value v becomes "everything but v excluded"; anything else is empty.
    always_comb begin
        load_cell_d = '0;
        if (in_value != '0 && in_value <= VAL_W'(WIDTH)) begin
            load_cell_d = ~(WIDTH'(1) << (in_value - VAL_W'(1)));
        end
    end

    cell_decode #(.WIDTH(WIDTH)) u_out_dec (
        .cell_i   (grid_q[cnt_q]),
        .value_o  (out_dec_value),
        .solved_o (out_solved_unused)
    );

    assign options    = grid_q;
    assign in_ready   = (state_q == LOAD);
    assign out_valid  = (state_q == OUTPUT);
    assign out_value  = out_valid ? out_dec_value : '0;
    assign status     = status_q;
    assign iter_count = iter_q;

    // Controller FSM: load, iterate the merge, stream results.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= LOAD;
            status_q <= ST_NONE;
            grid_q   <= '0;
            cnt_q    <= '0;
            iter_q   <= '0;
`ifdef PROP_PIPE_EN
            elim_q   <= '0;
`endif
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_valid) begin
                        grid_q[cnt_q] <= load_cell_d;
                        status_q      <= ST_NONE;
                        iter_q        <= '0;
                        if (cnt_q == LAST_CELL) begin
                            cnt_q <= '0;
`ifdef PROP_PIPE_EN
                            state_q <= EVAL;
`else
                            state_q <= PROPAGATE;
`endif
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
`ifdef PROP_PIPE_EN
                EVAL: begin
                    elim_q  <= elim_d;
                    state_q <= APPLY;
                end
                APPLY: begin
                    grid_q <= merged_d;
                    if (iter_q != ITER_SAT) begin
                        iter_q <= iter_q + ITER_W'(1);
                    end
                    if (result_d != ST_NONE) begin
                        status_q <= result_d;
                        state_q  <= OUTPUT;
                    end else begin
                        state_q  <= EVAL;
                    end
                end
`else
                PROPAGATE: begin
                    grid_q <= merged_d;
                    if (iter_q != ITER_SAT) begin
                        iter_q <= iter_q + ITER_W'(1);
                    end
                    if (result_d != ST_NONE) begin
                        status_q <= result_d;
                        state_q  <= OUTPUT;
                    end
                end
`endif
                OUTPUT: begin
                    if (out_ready) begin
                        if (cnt_q == LAST_CELL) begin
                            cnt_q   <= '0;
                            grid_q  <= '0;
                            state_q <= LOAD;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_propagation_ctrl.sv
// Scenario bench for propagation_ctrl (WIDTH=4, N=2, MAX_ITER=8) with a
// bench-side solver stub driving the elimination masks.
module tb_propagation_ctrl;
    import sudoku_pkg::*;

    localparam int W     = 4;
    localparam int CELLS = 16;

    logic                      clock = 1'b0;
    logic                      reset = 1'b1;
    logic                      in_valid = 1'b0;
    logic                      in_ready;
    logic [2:0]                in_value = '0;
    logic [3:0][3:0][3:0]      options;
    logic [3:0][3:0][3:0]      elim_row;
    logic [3:0][3:0][3:0]      elim_col;
    logic [3:0][3:0][3:0]      elim_sector;
    logic                      out_valid;
    logic                      out_ready = 1'b0;
    logic [2:0]                out_value;
    status_t                   status;
    logic [3:0]                iter_count;

    int checks = 0;
    int errors = 0;
    int stub_mode = 0;
    int exp_q[$];

    int grid1[16]     = '{1,2,3,4, 3,4,1,2, 2,1,4,3, 4,3,2,1};
    int zeros[16]     = '{default: 0};
    int cell0_only[16] = '{1,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};
    int pat_all[4]    = '{1,1,1,1};
    int pat_bp[4]     = '{1,0,0,1};

    logic [15:0][3:0] opt_flat;
    logic [15:0][3:0] stub_flat;
    logic             stub_found;

    propagation_ctrl #(.WIDTH(4), .N(2), .MAX_ITER(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_value    (in_value),
        .options     (options),
        .elim_row    (elim_row),
        .elim_col    (elim_col),
        .elim_sector (elim_sector),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_value   (out_value),
        .status      (status),
        .iter_count  (iter_count)
    );

    always #5 clock = ~clock;

    assign opt_flat    = options;
    assign elim_col    = stub_flat;
    assign elim_sector = '0;

    // Stub mode 1: exclude value 1 in the first cell that still allows it.
    always_comb begin
        stub_flat  = '0;
        stub_found = 1'b0;
        if (stub_mode == 1) begin
            for (int k = 0; k < CELLS; k++) begin
                if (!stub_found && !opt_flat[k][0]) begin
                    stub_flat[k][0] = 1'b1;
                    stub_found      = 1'b1;
                end
            end
        end
    end

    // Stub mode 2: row mask excludes value 1 from cell 0.
    always_comb begin
        elim_row = '0;
        if (stub_mode == 2) begin
            elim_row[0][0][0] = 1'b1;
        end
    end

    task automatic load_grid(input int vals[16], input int n_cells);
        for (int i = 0; i < n_cells; i++) begin
            in_valid = 1'b1;
            in_value = 3'(vals[i]);
            @(negedge clock);
            if (i == 0) begin
                checks++;
                if (status !== ST_NONE || iter_count !== 4'd0) begin
                    errors++;
                    $display("FAIL load_clear status=%0d iter=%0d required status=%0d iter=0",
                             status, iter_count, ST_NONE);
                end
            end
        end
        in_valid = 1'b0;
        in_value = '0;
    endtask

    task automatic run_to_output(input status_t exp_st, input int exp_iter, input string name);
        int cycles = 0;
        while (out_valid !== 1'b1 && cycles < 40) begin
            @(negedge clock);
            cycles++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_reach_output out_valid=%b required 1 within 40 cycles", name, out_valid);
        end else begin
            checks++;
            if (status !== exp_st) begin
                errors++;
                $display("FAIL %s_status got %0d required %0d", name, status, exp_st);
            end
            checks++;
            if (iter_count !== 4'(exp_iter)) begin
                errors++;
                $display("FAIL %s_iter got %0d required %0d", name, iter_count, exp_iter);
            end
            checks++;
            if (cycles != exp_iter) begin
                errors++;
                $display("FAIL %s_cycles got %0d required %0d", name, cycles, exp_iter);
            end
        end
    endtask

    task automatic drain(input int pat[4], input status_t exp_st, input string name);
        int hs = 0;
        int k = 0;
        logic [2:0] prev = '0;
        bit prev_stall = 1'b0;
        while (exp_q.size() > 0 && k < 200) begin
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL %s_out_valid got %b required 1 at cycle %0d", name, out_valid, k);
            end
            checks++;
            if (out_value !== 3'(exp_q[0])) begin
                errors++;
                $display("FAIL %s_value cell %0d got %0d required %0d", name, hs, out_value, exp_q[0]);
            end
            if (prev_stall) begin
                checks++;
                if (out_value !== prev) begin
                    errors++;
                    $display("FAIL %s_hold got %0d required %0d", name, out_value, prev);
                end
            end
            out_ready  = pat[k % 4][0];
            prev       = out_value;
            prev_stall = !out_ready;
            @(negedge clock);
            if (out_ready) begin
                $display("%s: out cell %0d value %0d", name, hs, prev);
                void'(exp_q.pop_front());
                hs++;
            end
            k++;
        end
        out_ready = 1'b0;
        exp_q.delete();
        checks++;
        if (hs != CELLS) begin
            errors++;
            $display("FAIL %s_handshakes got %0d required %0d", name, hs, CELLS);
        end
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_back_to_load in_ready=%b out_valid=%b required 1 0", name, in_ready, out_valid);
        end
        checks++;
        if (options !== '0) begin
            errors++;
            $display("FAIL %s_options_cleared got %h required 0", name, options);
        end
        checks++;
        if (status !== exp_st) begin
            errors++;
            $display("FAIL %s_status_hold got %0d required %0d", name, status, exp_st);
        end
    endtask

    task automatic push_grid(input int vals[16]);
        for (int i = 0; i < CELLS; i++) exp_q.push_back(vals[i]);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_value !== 3'd0) begin
            errors++;
            $display("FAIL reset_handshake in_ready=%b out_valid=%b out_value=%0d required 1 0 0",
                     in_ready, out_valid, out_value);
        end
        checks++;
        if (status !== ST_NONE || iter_count !== 4'd0 || options !== '0) begin
            errors++;
            $display("FAIL reset_state status=%0d iter=%0d options=%h required 0 0 0",
                     status, iter_count, options);
        end
        reset = 1'b0;
    endtask

    task automatic test_solved();
        stub_mode = 0;
        load_grid(grid1, CELLS);
        push_grid(grid1);
        run_to_output(ST_SOLVED, 1, "solved");
        drain(pat_all, ST_SOLVED, "solved");
    endtask

    task automatic test_stalled();
        stub_mode = 0;
        load_grid(zeros, CELLS);
        push_grid(zeros);
        run_to_output(ST_STALLED, 1, "stalled");
        drain(pat_all, ST_STALLED, "stalled");
    endtask

    task automatic test_timeout();
        stub_mode = 1;
        load_grid(zeros, CELLS);
        push_grid(zeros);
        run_to_output(ST_TIMEOUT, 8, "timeout");
        drain(pat_all, ST_TIMEOUT, "timeout");
        stub_mode = 0;
    endtask

    task automatic test_contra();
        stub_mode = 2;
        load_grid(cell0_only, CELLS);
        push_grid(zeros);
        run_to_output(ST_CONTRA, 1, "contra");
        drain(pat_all, ST_CONTRA, "contra");
        stub_mode = 0;
    endtask

    // Every other cell resolved, cell 0 contradicted: contradiction wins.
    task automatic test_contra_over_solved();
        stub_mode = 2;
        load_grid(grid1, CELLS);
        exp_q.push_back(0);
        for (int i = 1; i < CELLS; i++) exp_q.push_back(grid1[i]);
        run_to_output(ST_CONTRA, 1, "contra_solved");
        drain(pat_all, ST_CONTRA, "contra_solved");
        stub_mode = 0;
    endtask

    task automatic test_backpressure();
        stub_mode = 0;
        load_grid(grid1, CELLS);
        push_grid(grid1);
        run_to_output(ST_SOLVED, 1, "backpressure");
        drain(pat_bp, ST_SOLVED, "backpressure");
    endtask

    task automatic test_reset_midload();
        stub_mode = 0;
        load_grid(grid1, 7);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || status !== ST_NONE || options !== '0) begin
            errors++;
            $display("FAIL midload_reset in_ready=%b status=%0d options=%h required 1 0 0",
                     in_ready, status, options);
        end
        load_grid(grid1, CELLS);
        push_grid(grid1);
        run_to_output(ST_SOLVED, 1, "reload");
        drain(pat_all, ST_SOLVED, "reload");
    endtask

    initial begin
        test_reset();
        test_solved();
        test_stalled();
        test_timeout();
        test_contra();
        test_contra_over_solved();
        test_backpressure();
        test_reset_midload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
